// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - op codes, FSM states and lane constants for the MEM stage
package mem_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'b100001;
  localparam logic [5:0] OP_LH  = 6'b101011;
  localparam logic [5:0] OP_LBU = 6'b101010;
  localparam logic [5:0] OP_LHU = 6'b101100;
  localparam logic [5:0] OP_LWL = 6'b101101;
  localparam logic [5:0] OP_LWR = 6'b101110;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b110000;
  localparam logic [5:0] OP_SH  = 6'b110001;
  localparam logic [5:0] OP_SW  = 6'b110010;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - big-endian load alignment and LWL/LWR merge (combinational)
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [1:0]      offset_i,
  input  logic [31:0]     rdata_i,
  input  logic [31:0]     base_i,
  output logic [31:0]     data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Offset 0 is the most significant lane, so byte k sits 8*(3-k) bits up.
  always_comb begin
    byte_sel = 8'(rdata_i >> {~offset_i, 3'b000});
    half_sel = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    data_o   = '0;
    case (op_i)
      OP_W'(OP_LB):  data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_W'(OP_LBU): data_o = {24'd0, byte_sel};
      OP_W'(OP_LH):  data_o = {{16{half_sel[15]}}, half_sel};
      OP_W'(OP_LHU): data_o = {16'd0, half_sel};
      OP_W'(OP_LW):  data_o = rdata_i;
      OP_W'(OP_LWL): data_o = (rdata_i << {offset_i, 3'b000})
                            | (base_i & ~(32'hFFFF_FFFF << {offset_i, 3'b000}));
      OP_W'(OP_LWR): data_o = (rdata_i >> {~offset_i, 3'b000})
                            | (base_i & ~(32'hFFFF_FFFF >> {~offset_i, 3'b000}));
      default:       data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - MEM pipeline stage with req/ack handshake to a variable-latency data memory
// Defining MEM_STATS_EN adds saturating load/store/wait-cycle counters.
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FREEZE,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic [31:0]       ex_store_data,
  input  logic [31:0]       ex_dest_old,
  input  logic [REG_W-1:0]  ex_wreg,
  input  logic              ex_wb_en,
  input  logic              ex_mem2reg,
  input  logic              wb_wen,
  input  logic [REG_W-1:0]  wb_wreg,
  input  logic [31:0]       wb_wdata,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [BE_W-1:0]   dm_be,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              stall_o,
  output logic [31:0]       fwd_data,
  output logic              pr_valid,
  output logic              pr_wb_en,
  output logic              pr_mem2reg,
  output logic [REG_W-1:0]  pr_wreg,
  output logic [31:0]       pr_alu,
  output logic [31:0]       pr_rdata,
`ifdef MEM_STATS_EN
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_wait_cycles,
`endif
  output logic              err_align,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_hit;
  logic              dm_req_q, dm_we_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [31:0]       dm_wdata_q;
  logic [BE_W-1:0]   dm_be_q;
  logic [31:0]       hold_q;
  logic              suppress_q;
  logic              pr_valid_q, pr_wb_en_q, pr_mem2reg_q;
  logic [REG_W-1:0]  pr_wreg_q;
  logic [31:0]       pr_alu_q, pr_rdata_q;
  logic              err_align_q, err_timeout_q;

  logic              op_load, op_store, is_mem, misalign, start, fwd_hit;
  logic [31:0]       st_src, base_src, ld_aligned, wdata_c;
  logic [BE_W-1:0]   be_c;

  always_comb begin
    op_load  = ex_op inside {OP_W'(OP_LB), OP_W'(OP_LH), OP_W'(OP_LBU), OP_W'(OP_LHU),
                             OP_W'(OP_LWL), OP_W'(OP_LWR), OP_W'(OP_LW)};
    op_store = ex_op inside {OP_W'(OP_SB), OP_W'(OP_SH), OP_W'(OP_SW)};
    is_mem   = ex_valid & (op_load | op_store);
    misalign = is_mem &
               (((ex_op inside {OP_W'(OP_LH), OP_W'(OP_LHU), OP_W'(OP_SH)}) & ex_addr[0]) |
                ((ex_op inside {OP_W'(OP_LW), OP_W'(OP_SW)}) & (ex_addr[1:0] != 2'b00)));
    start    = (state_q == IDLE) & is_mem & ~misalign;
    fwd_hit  = wb_wen & (wb_wreg == ex_rt) & (ex_rt != '0);
    st_src   = fwd_hit ? wb_wdata : ex_store_data;
    base_src = fwd_hit ? wb_wdata : ex_dest_old;
    be_c     = 4'b1111;
    wdata_c  = '0;
    case (ex_op)
      OP_W'(OP_SB): begin
        be_c    = 4'b1000 >> ex_addr[1:0];
        wdata_c = {4{st_src[7:0]}};
      end
      OP_W'(OP_SH): begin
        be_c    = ex_addr[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{st_src[15:0]}};
      end
      OP_W'(OP_SW): wdata_c = st_src;
      default: ;
    endcase
  end

  mem_load_align #(.OP_W(OP_W)) u_align (
    .op_i     (ex_op),
    .offset_i (ex_addr[1:0]),
    .rdata_i  (dm_rdata),
    .base_i   (base_src),
    .data_o   (ld_aligned)
  );

  // FREEZE only gates IDLE->WAIT and DONE->IDLE; the handshake itself runs free.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: if (start && !FREEZE) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dm_ack) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE: if (!FREEZE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
      dm_be_q       <= '0;
      hold_q        <= '0;
      suppress_q    <= 1'b0;
      pr_valid_q    <= 1'b0;
      pr_wb_en_q    <= 1'b0;
      pr_mem2reg_q  <= 1'b0;
      pr_wreg_q     <= '0;
      pr_alu_q      <= '0;
      pr_rdata_q    <= '0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_align_q   <= 1'b0;
      err_timeout_q <= timeout_hit;
      case (state_q)
        IDLE: if (!FREEZE) begin
          if (start) begin
            dm_req_q   <= 1'b1;
            dm_we_q    <= op_store;
            dm_addr_q  <= {ex_addr[ADDR_W-1:2], 2'b00};
            dm_be_q    <= be_c;
            dm_wdata_q <= wdata_c;
            suppress_q <= 1'b0;
            // Bubble into MEM/WB while the access is outstanding.
            pr_valid_q <= 1'b0;
            pr_wb_en_q <= 1'b0;
          end else begin
            pr_valid_q   <= ex_valid;
            pr_wb_en_q   <= ex_wb_en & ~misalign;
            pr_mem2reg_q <= ex_mem2reg;
            pr_wreg_q    <= ex_wreg;
            pr_alu_q     <= 32'(ex_addr);
            pr_rdata_q   <= '0;
            err_align_q  <= misalign;
          end
        end
        WAIT: begin
          if (dm_ack) begin
            dm_req_q <= 1'b0;
            hold_q   <= ld_aligned;
          end else if (timeout_hit) begin
            dm_req_q   <= 1'b0;
            hold_q     <= '0;
            suppress_q <= 1'b1;
          end
        end
        DONE: if (!FREEZE) begin
          pr_valid_q   <= ex_valid;
          pr_wb_en_q   <= ex_wb_en & ~suppress_q;
          pr_mem2reg_q <= ex_mem2reg;
          pr_wreg_q    <= ex_wreg;
          pr_alu_q     <= 32'(ex_addr);
          pr_rdata_q   <= hold_q;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_STATS_EN
  logic [31:0] stat_loads_q, stat_stores_q, stat_wait_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_wait_q   <= '0;
    end else begin
      if (state_q == DONE && !FREEZE) begin
        if (op_load && stat_loads_q != '1)   stat_loads_q  <= stat_loads_q + 1'b1;
        if (op_store && stat_stores_q != '1) stat_stores_q <= stat_stores_q + 1'b1;
      end
      if (state_q == WAIT && stat_wait_q != '1) stat_wait_q <= stat_wait_q + 1'b1;
    end
  end

  assign stat_loads       = stat_loads_q;
  assign stat_stores      = stat_stores_q;
  assign stat_wait_cycles = stat_wait_q;
`endif

  assign stall_o     = start | (state_q == WAIT);
  assign fwd_data    = (state_q == DONE) ? hold_q : 32'(ex_addr);
  assign dm_req      = dm_req_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;
  assign dm_be       = dm_be_q;
  assign pr_valid    = pr_valid_q;
  assign pr_wb_en    = pr_wb_en_q;
  assign pr_mem2reg  = pr_mem2reg_q;
  assign pr_wreg     = pr_wreg_q;
  assign pr_alu      = pr_alu_q;
  assign pr_rdata    = pr_rdata_q;
  assign err_align   = err_align_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - scoreboard bench for mem_stage_hs with directed vectors
module tb_mem_stage_hs;
  import mem_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, FREEZE, ex_valid, ex_wb_en, ex_mem2reg, wb_wen, dm_ack;
  logic [5:0]  ex_op;
  logic [31:0] ex_addr, ex_store_data, ex_dest_old, wb_wdata, dm_rdata;
  logic [4:0]  ex_rt, ex_wreg, wb_wreg;
  logic        dm_req, dm_we, stall_o, pr_valid, pr_wb_en, pr_mem2reg, err_align, err_timeout;
  logic [31:0] dm_addr, dm_wdata, fwd_data, pr_alu, pr_rdata;
  logic [3:0]  dm_be;
  logic [4:0]  pr_wreg;

  always #5 CLK = ~CLK;

  mem_stage_hs #(.ADDR_W(32), .REG_W(5), .OP_W(6), .TIMEOUT(64)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr), .ex_rt(ex_rt),
    .ex_store_data(ex_store_data), .ex_dest_old(ex_dest_old), .ex_wreg(ex_wreg),
    .ex_wb_en(ex_wb_en), .ex_mem2reg(ex_mem2reg),
    .wb_wen(wb_wen), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall_o(stall_o), .fwd_data(fwd_data),
    .pr_valid(pr_valid), .pr_wb_en(pr_wb_en), .pr_mem2reg(pr_mem2reg), .pr_wreg(pr_wreg),
    .pr_alu(pr_alu), .pr_rdata(pr_rdata),
    .err_align(err_align), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic        valid, wb_en, m2r;
    logic [4:0]  wreg;
    logic [31:0] alu, rdata;
  } pr_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dm_t;

  pr_t pr_exp[$];
  dm_t dm_exp[$];
  int  n_checks = 0, n_pass = 0, n_align = 0, n_tmo = 0;
  int  stalls;
  logic prev_req = 1'b0;

  function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a PR capture or a new request.
  always @(negedge CLK) begin
    if (pr_valid) begin
      if (pr_exp.size() == 0)
        check("pr_unexpected", 96'({pr_valid, pr_wb_en, pr_mem2reg, pr_wreg, pr_alu, pr_rdata}), 96'(0));
      else
        check("pr_capture", 96'({pr_valid, pr_wb_en, pr_mem2reg, pr_wreg, pr_alu, pr_rdata}),
              96'(pr_exp.pop_front()));
    end
    if (dm_req && !prev_req) begin
      if (dm_exp.size() == 0)
        check("dm_unexpected", 96'({dm_we, dm_addr, dm_be, dm_wdata}), 96'(0));
      else
        check("dm_request", 96'({dm_we, dm_addr, dm_be, dm_wdata}), 96'(dm_exp.pop_front()));
    end
    prev_req <= dm_req;
    if (err_align)   n_align++;
    if (err_timeout) n_tmo++;
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] dold, input logic [4:0] rt, input logic [4:0] wreg,
                       input logic wbe, input logic m2r, input logic fwd, input logic [31:0] wbd,
                       input int ack_at, input logic [31:0] rd, output int n_stall);
    int waitn;
    int guard;
    ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_store_data = sd; ex_dest_old = dold;
    ex_rt = rt; ex_wreg = wreg; ex_wb_en = wbe; ex_mem2reg = m2r;
    wb_wen = fwd; wb_wreg = rt; wb_wdata = wbd;
    n_stall = 0; waitn = 0; guard = 0;
    #1;
    while (stall_o && guard < 200) begin
      n_stall++; guard++;
      @(posedge CLK); #1;
      dm_ack = 1'b0;
      if (dm_req) begin
        waitn++;
        if (waitn == ack_at) begin dm_ack = 1'b1; dm_rdata = rd; end
      end
      #1;
    end
    if (guard >= 200) check("handshake_bound", 96'(guard), 96'(0));
  endtask

  task automatic finish_op();
    @(posedge CLK); #1;
    ex_valid = 1'b0; wb_wen = 1'b0; dm_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; FREEZE = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_addr = '0; ex_rt = '0;
    ex_store_data = '0; ex_dest_old = '0; ex_wreg = '0; ex_wb_en = 1'b0; ex_mem2reg = 1'b0;
    wb_wen = 1'b0; wb_wreg = '0; wb_wdata = '0; dm_ack = 1'b0; dm_rdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_pr", 96'({pr_valid, pr_wb_en, pr_mem2reg, pr_wreg, pr_alu, pr_rdata}), 96'(0));
    check("reset_dm", 96'({dm_req, dm_we, dm_addr, dm_be, dm_wdata}), 96'(0));
    check("reset_flags", 96'({stall_o, err_align, err_timeout}), 96'(0));
    RESET = 1'b0;

    // Non-memory op: single-edge capture, fwd_data is the ALU result.
    pr_exp.push_back('{1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_1234, 32'h0});
    issue(6'b000000, 32'h1234, 32'h0, 32'h0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0, 0, 32'h0, stalls);
    check("alu_stall", 96'(stalls), 96'(0));
    check("alu_fwd_data", 96'(fwd_data), 96'h1234);
    finish_op();

    // LB at 0x103, ack in the 2nd WAIT cycle.
    dm_exp.push_back('{1'b0, 32'h100, 4'b1111, 32'h0});
    pr_exp.push_back('{1'b1, 1'b1, 1'b1, 5'd5, 32'h103, 32'hFFFF_FFF4});
    issue(OP_LB, 32'h103, 32'h0, 32'h0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h0, 2, 32'h1122_33F4, stalls);
    check("lb_stall_cycles", 96'(stalls), 96'(3));
    check("lb_fwd_hold", 96'(fwd_data), 96'hFFFF_FFF4);
    finish_op();

    // SH at 0x202 with rt forwarded from WB.
    dm_exp.push_back('{1'b1, 32'h200, 4'b0011, 32'h5678_5678});
    pr_exp.push_back('{1'b1, 1'b0, 1'b0, 5'd0, 32'h202, 32'h0});
    issue(OP_SH, 32'h202, 32'h0000_BEEF, 32'h0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1, 32'h0, stalls);
    check("sh_stall_cycles", 96'(stalls), 96'(2));
    finish_op();

    // SB at offset 1 without forwarding.
    dm_exp.push_back('{1'b1, 32'h0, 4'b0100, 32'hABAB_ABAB});
    pr_exp.push_back('{1'b1, 1'b0, 1'b0, 5'd0, 32'h1, 32'h0});
    issue(OP_SB, 32'h1, 32'h0000_00AB, 32'h0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 32'h0, stalls);
    finish_op();

    // LWL offset 1 and LWR offset 1 (base forwarded from WB).
    dm_exp.push_back('{1'b0, 32'h10, 4'b1111, 32'h0});
    pr_exp.push_back('{1'b1, 1'b1, 1'b1, 5'd8, 32'h11, 32'h2233_44DD});
    issue(OP_LWL, 32'h11, 32'h0, 32'hAABB_CCDD, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0, 1, 32'h1122_3344, stalls);
    finish_op();
    dm_exp.push_back('{1'b0, 32'h14, 4'b1111, 32'h0});
    pr_exp.push_back('{1'b1, 1'b1, 1'b1, 5'd9, 32'h15, 32'hAABB_1122});
    issue(OP_LWR, 32'h15, 32'h0, 32'h0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 32'hAABB_CCDD, 1, 32'h1122_3344, stalls);
    finish_op();

    // LHU, LH, LBU, LW alignment patterns.
    dm_exp.push_back('{1'b0, 32'h20, 4'b1111, 32'h0});
    pr_exp.push_back('{1'b1, 1'b1, 1'b1, 5'd4, 32'h22, 32'h0000_F344});
    issue(OP_LHU, 32'h22, 32'h0, 32'h0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0, 3, 32'h1122_F344, stalls);
    finish_op();
    dm_exp.push_back('{1'b0, 32'h20, 4'b1111, 32'h0});
    pr_exp.push_back('{1'b1, 1'b1, 1'b1, 5'd4, 32'h20, 32'hFFFF_8001});
    issue(OP_LH, 32'h20, 32'h0, 32'h0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0, 1, 32'h8001_0000, stalls);
    finish_op();
    dm_exp.push_back('{1'b0, 32'h100, 4'b1111, 32'h0});
    pr_exp.push_back('{1'b1, 1'b1, 1'b1, 5'd6, 32'h101, 32'h0000_00F2});
    issue(OP_LBU, 32'h101, 32'h0, 32'h0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 32'h0, 1, 32'h11F2_3344, stalls);
    finish_op();

    // LW held in DONE by FREEZE: no capture until released.
    dm_exp.push_back('{1'b0, 32'h40, 4'b1111, 32'h0});
    pr_exp.push_back('{1'b1, 1'b1, 1'b1, 5'd2, 32'h40, 32'hDEAD_BEEF});
    issue(OP_LW, 32'h40, 32'h0, 32'h0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, stalls);
    FREEZE = 1'b1;
    repeat (2) @(posedge CLK);
    #2;
    check("freeze_hold", 96'({pr_valid, fwd_data}), 96'({1'b0, 32'hDEAD_BEEF}));
    FREEZE = 1'b0;
    finish_op();

    // Misaligned LW: no request, no stall, wb_en cleared, err_align pulse.
    pr_exp.push_back('{1'b1, 1'b0, 1'b1, 5'd2, 32'h6, 32'h0});
    issue(OP_LW, 32'h6, 32'h0, 32'h0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0, 1, 32'h0, stalls);
    check("misalign_stall", 96'(stalls), 96'(0));
    finish_op();

    // Timeout: no ack ever.
    dm_exp.push_back('{1'b0, 32'h80, 4'b1111, 32'h0});
    pr_exp.push_back('{1'b1, 1'b0, 1'b1, 5'd2, 32'h80, 32'h0});
    issue(OP_LW, 32'h80, 32'h0, 32'h0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0, 0, 32'h0, stalls);
    check("timeout_stall_cycles", 96'(stalls), 96'(65));
    check("timeout_pulse", 96'({err_timeout, dm_req}), 96'({1'b1, 1'b0}));
    finish_op();
    dm_ack = 1'b1; dm_rdata = 32'h5555_5555;
    @(posedge CLK); #1;
    dm_ack = 1'b0;
    #1;
    check("late_ack_ignored", 96'({dm_req, stall_o, fwd_data}), 96'({1'b0, 1'b0, 32'h80}));

    // Reset in the middle of WAIT.
    dm_exp.push_back('{1'b0, 32'h300, 4'b1111, 32'h0});
    ex_valid = 1'b1; ex_op = OP_LW; ex_addr = 32'h300; ex_wreg = 5'd1; ex_wb_en = 1'b1; ex_mem2reg = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    ex_valid = 1'b0;
    RESET = 1'b1;
    #1;
    check("reset_mid_dm_req", 96'(dm_req), 96'(0));
    check("reset_mid_pr", 96'({pr_valid, pr_wb_en, pr_mem2reg, pr_wreg, pr_alu, pr_rdata}), 96'(0));
    @(posedge CLK); #1;
    RESET = 1'b0;
    dm_exp.push_back('{1'b0, 32'h400, 4'b1111, 32'h0});
    pr_exp.push_back('{1'b1, 1'b1, 1'b1, 5'd1, 32'h400, 32'hCAFE_BABE});
    issue(OP_LW, 32'h400, 32'h0, 32'h0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 32'h0, 1, 32'hCAFE_BABE, stalls);
    check("post_reset_stall", 96'(stalls), 96'(2));
    finish_op();

    repeat (3) @(posedge CLK);
    #1;
    check("pr_queue_drained", 96'(pr_exp.size()), 96'(0));
    check("dm_queue_drained", 96'(dm_exp.size()), 96'(0));
    check("err_align_count", 96'(n_align), 96'(1));
    check("err_timeout_count", 96'(n_tmo), 96'(1));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
